ttt_turn_ctrl: RTL and testbench



---
 rtl/ttt_turn_ctrl_pkg.sv | 42 ++++
 rtl/ttt_turn_ctrl_line_check.sv | 18 +
 rtl/ttt_turn_ctrl.sv | 155 +++++++++++++++
 tb/tb_ttt_turn_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_turn_ctrl_pkg.sv
// Shared constants for the tic-tac-toe turn controller: cell masks, win lines,
// winner codes and FSM state encoding.
package ttt_turn_ctrl_pkg;

  localparam logic [8:0] CENTRE_MASK = 9'b000010000;
  localparam logic [8:0] CORNER_MASK = 9'b101000101;
  localparam logic [8:0] EDGE_MASK   = 9'b010101010;
  localparam logic [8:0] FULL_BOARD  = 9'h1FF;

  localparam int unsigned NUM_LINES = 8;

  // Rows, columns, then the two diagonals; bit i = cell i, row-major.
  localparam logic [NUM_LINES-1:0][8:0] LINE_MASKS = {
    9'b001010100, 9'b100010001,
    9'b100100100, 9'b010010010, 9'b001001001,
    9'b111000000, 9'b000111000, 9'b000000111
  };

  typedef enum logic [1:0] {
    WinNone  = 2'b00,
    WinHuman = 2'b01,
    WinComp  = 2'b10,
    WinDraw  = 2'b11
  } winner_e;

  typedef enum logic [2:0] {
    StWaitH  = 3'd0,
    StCheckH = 3'd1,
    StThink  = 3'd2,
    StCheckC = 3'd3,
    StDone   = 3'd4
  } state_e;

  function automatic logic is_onehot9(logic [8:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

  function automatic logic [8:0] lowest_bit(logic [8:0] v);
    return v & (~v + 9'd1);
  endfunction

endpackage

// File: rtl/ttt_turn_ctrl_line_check.sv
// Flags whether a 9-cell board contains any complete row, column or diagonal.
module ttt_turn_ctrl_line_check
  import ttt_turn_ctrl_pkg::*;
(
  input  logic [8:0] board_i,
  output logic       has_line_o
);

  always_comb begin
    has_line_o = 1'b0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if ((board_i & LINE_MASKS[i]) == LINE_MASKS[i]) begin
        has_line_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Turn controller: holds both boards, accepts human moves, arbitrates the
// computer move from the strategy candidates and detects win/draw.
module ttt_turn_ctrl
  import ttt_turn_ctrl_pkg::*;
#(
  parameter bit          COMP_FIRST   = 1'b0,
  parameter int unsigned THINK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic [8:0] human_move,
  input  logic       human_valid,
  input  logic [8:0] win_cand,
  input  logic [8:0] block_cand,
  input  logic [8:0] adj_cand,
  output logic [8:0] ain,
  output logic [8:0] bin,
  output logic [8:0] comp_move,
  output logic       move_err,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [3:0] THINK_LOAD = 4'(THINK_CYCLES - 1);
  localparam state_e     START_ST   = COMP_FIRST ? StThink : StWaitH;

  state_e     state_q, state_d;
  winner_e    winner_q, winner_d;
  logic [8:0] ain_q, ain_d, bin_q, bin_d, comp_move_q, comp_move_d;
  logic       move_err_q, move_err_d;
  logic [3:0] cnt_q, cnt_d;

  logic       human_line, comp_line;
  logic [8:0] occupied, empty, pick_vec, pick;

  ttt_turn_ctrl_line_check u_line_h (
    .board_i    (ain_q),
    .has_line_o (human_line)
  );

  ttt_turn_ctrl_line_check u_line_c (
    .board_i    (bin_q),
    .has_line_o (comp_line)
  );

  assign occupied = ain_q | bin_q;
  assign empty    = ~occupied;

  // Strategy priority; the final edge fallback is never empty when THINK runs.
  always_comb begin
    if ((win_cand & empty) != '0) begin
      pick_vec = win_cand & empty;
    end else if ((block_cand & empty) != '0) begin
      pick_vec = block_cand & empty;
    end else if ((adj_cand & empty) != '0) begin
      pick_vec = adj_cand & empty;
    end else if ((CENTRE_MASK & empty) != '0) begin
      pick_vec = CENTRE_MASK & empty;
    end else if ((CORNER_MASK & empty) != '0) begin
      pick_vec = CORNER_MASK & empty;
    end else begin
      pick_vec = EDGE_MASK & empty;
    end
    pick = lowest_bit(pick_vec);
  end

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    ain_d       = ain_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    comp_move_d = '0;
    move_err_d  = 1'b0;
    unique case (state_q)
      StWaitH: begin
        if (human_valid) begin
          if (is_onehot9(human_move) && ((human_move & occupied) == '0)) begin
            ain_d   = ain_q | human_move;
            state_d = StCheckH;
          end else begin
            move_err_d = 1'b1;
          end
        end
      end
      StCheckH: begin
        if (human_line) begin
          state_d  = StDone;
          winner_d = WinHuman;
        end else if (occupied == FULL_BOARD) begin
          state_d  = StDone;
          winner_d = WinDraw;
        end else begin
          state_d = StThink;
          cnt_d   = THINK_LOAD;
        end
      end
      StThink: begin
        if (cnt_q == '0) begin
          bin_d       = bin_q | pick;
          comp_move_d = pick;
          state_d     = StCheckC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCheckC: begin
        if (comp_line) begin
          state_d  = StDone;
          winner_d = WinComp;
        end else if (occupied == FULL_BOARD) begin
          state_d  = StDone;
          winner_d = WinDraw;
        end else begin
          state_d = StWaitH;
        end
      end
      StDone: ;
      default: state_d = StWaitH;
    endcase
  end

  // Counter restarts at the full think time so a computer-first opening also
  // gets the strategy settling delay.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state_q     <= START_ST;
      winner_q    <= WinNone;
      ain_q       <= '0;
      bin_q       <= '0;
      comp_move_q <= '0;
      move_err_q  <= 1'b0;
      cnt_q       <= THINK_LOAD;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      comp_move_q <= comp_move_d;
      move_err_q  <= move_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ain       = ain_q;
  assign bin       = bin_q;
  assign comp_move = comp_move_q;
  assign move_err  = move_err_q;
  assign winner    = winner_q;
  assign game_over = (state_q == StDone);
  assign state     = state_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Self-checking bench for ttt_turn_ctrl: directed turn table, random games
// against a board-level model, and think-abort cases on a slow instance.
module tb_ttt_turn_ctrl;
  import ttt_turn_ctrl_pkg::*;

  localparam int THINK1 = 1;
  localparam int THINK4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, new_game = 1'b0, human_valid = 1'b0;
  logic [8:0] human_move = '0, win_cand = '0, block_cand = '0, adj_cand = '0;
  logic [8:0] ain, bin, comp_move;
  logic       move_err, game_over;
  logic [1:0] winner;
  logic [2:0] state;

  logic       rst4 = 1'b1, ng4 = 1'b0, hv4 = 1'b0;
  logic [8:0] hm4 = '0;
  logic [8:0] ain4, bin4, cm4;
  logic       err4, go4;
  logic [1:0] win4;
  logic [2:0] st4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ttt_turn_ctrl #(.COMP_FIRST(1'b0), .THINK_CYCLES(THINK1)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .human_move(human_move),
    .human_valid(human_valid), .win_cand(win_cand), .block_cand(block_cand),
    .adj_cand(adj_cand), .ain(ain), .bin(bin), .comp_move(comp_move),
    .move_err(move_err), .game_over(game_over), .winner(winner), .state(state)
  );

  ttt_turn_ctrl #(.COMP_FIRST(1'b0), .THINK_CYCLES(THINK4)) dut4 (
    .clk(clk), .rst(rst4), .new_game(ng4), .human_move(hm4),
    .human_valid(hv4), .win_cand(9'h000), .block_cand(9'h000),
    .adj_cand(9'h000), .ain(ain4), .bin(bin4), .comp_move(cm4),
    .move_err(err4), .game_over(go4), .winner(win4), .state(st4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (board-level rules) ----------------
  function automatic bit m_line(input logic [8:0] b);
    for (int k = 0; k < 3; k++) begin
      if (b[3*k] && b[3*k+1] && b[3*k+2]) return 1'b1;
      if (b[k] && b[k+3] && b[k+6]) return 1'b1;
    end
    return (b[0] && b[4] && b[8]) || (b[2] && b[4] && b[6]);
  endfunction

  function automatic logic [8:0] m_pick(input logic [8:0] wc, input logic [8:0] bc,
                                        input logic [8:0] ac, input logic [8:0] occ);
    logic [8:0] tiers [6];
    tiers[0] = wc & ~occ;
    tiers[1] = bc & ~occ;
    tiers[2] = ac & ~occ;
    for (int i = 0; i < 9; i++) begin
      bit mid_r = (i / 3 == 1);
      bit mid_c = (i % 3 == 1);
      tiers[3][i] = !occ[i] && mid_r && mid_c;
      tiers[4][i] = !occ[i] && !mid_r && !mid_c;
      tiers[5][i] = !occ[i] && (mid_r != mid_c);
    end
    for (int t = 0; t < 6; t++)
      for (int i = 0; i < 9; i++)
        if (tiers[t][i]) return 9'(1) << i;
    return '0;
  endfunction

  // ---------------- transactions ----------------
  task automatic do_reset(input bit use_ng);
    if (use_ng) new_game = 1'b1; else rst = 1'b1;
    tick();
    rst = 1'b0;
    new_game = 1'b0;
    chk("rst.ain", ain, 0);
    chk("rst.bin", bin, 0);
    chk("rst.comp_move", comp_move, 0);
    chk("rst.move_err", move_err, 0);
    chk("rst.game_over", game_over, 0);
    chk("rst.winner", winner, 0);
    chk("rst.state", state, StWaitH);
  endtask

  // exp_pick == 0 on a legal move means the game ends on the human placement.
  task automatic do_turn(input string tag, input logic [8:0] hm, input logic [8:0] wc,
                         input logic [8:0] bc, input logic [8:0] ac, input bit exp_err,
                         input logic [8:0] exp_ain, input logic [8:0] exp_bin,
                         input logic [8:0] exp_pick, input logic [1:0] exp_win);
    chk({tag, ".pre_state"}, state, StWaitH);
    human_move = hm; human_valid = 1'b1;
    win_cand = wc; block_cand = bc; adj_cand = ac;
    tick();
    human_valid = 1'b0; human_move = '0;
    if (exp_err) begin
      chk({tag, ".err"}, move_err, 1);
      chk({tag, ".err_ain"}, ain, exp_ain);
      chk({tag, ".err_bin"}, bin, exp_bin);
      chk({tag, ".err_state"}, state, StWaitH);
      tick();
      chk({tag, ".err_clear"}, move_err, 0);
    end else begin
      chk({tag, ".no_err"}, move_err, 0);
      chk({tag, ".ain"}, ain, exp_ain);
      chk({tag, ".check_h"}, state, StCheckH);
      tick();
      if (exp_pick == '0) begin
        chk({tag, ".h_done"}, state, StDone);
        chk({tag, ".h_over"}, game_over, 1);
        chk({tag, ".h_winner"}, winner, exp_win);
      end else begin
        for (int k = 0; k < THINK1; k++) begin
          chk({tag, ".think"}, state, StThink);
          chk({tag, ".think_cm"}, comp_move, 0);
          tick();
        end
        chk({tag, ".check_c"}, state, StCheckC);
        chk({tag, ".comp_move"}, comp_move, exp_pick);
        chk({tag, ".bin"}, bin, exp_bin);
        tick();
        chk({tag, ".cm_pulse"}, comp_move, 0);
        if (exp_win != 2'b00) begin
          chk({tag, ".c_done"}, state, StDone);
          chk({tag, ".c_over"}, game_over, 1);
        end else begin
          chk({tag, ".back_wait"}, state, StWaitH);
          chk({tag, ".not_over"}, game_over, 0);
        end
        chk({tag, ".winner"}, winner, exp_win);
      end
    end
    win_cand = '0; block_cand = '0; adj_cand = '0;
  endtask

  task automatic done_hold(input logic [8:0] exp_ain, input logic [8:0] exp_bin,
                           input logic [1:0] exp_win);
    for (int k = 0; k < 3; k++) begin
      human_move = 9'(1) << $urandom_range(0, 8);
      human_valid = 1'b1;
      tick();
      human_valid = 1'b0;
      chk("done.ain", ain, exp_ain);
      chk("done.bin", bin, exp_bin);
      chk("done.err", move_err, 0);
      chk("done.state", state, StDone);
      chk("done.over", game_over, 1);
      chk("done.winner", winner, exp_win);
    end
    human_move = '0;
  endtask

  task automatic abort_think(input bit use_ng, input int think_ticks);
    int pulses;
    rst4 = 1'b1; tick(); rst4 = 1'b0;
    hm4 = 9'h001; hv4 = 1'b1; tick(); hv4 = 1'b0;
    tick();
    for (int k = 0; k < think_ticks; k++) tick();
    chk("abort.in_think", st4, StThink);
    if (use_ng) ng4 = 1'b1; else rst4 = 1'b1;
    tick();
    ng4 = 1'b0; rst4 = 1'b0;
    chk("abort.ain", ain4, 0);
    chk("abort.bin", bin4, 0);
    chk("abort.state", st4, StWaitH);
    pulses = (cm4 != '0) ? 1 : 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (cm4 != '0 || st4 != StWaitH) pulses++;
    end
    chk("abort.no_comp_move", pulses, 0);
  endtask

  typedef struct {
    bit         restart;
    logic [8:0] hm, wc, bc, ac;
    bit         err;
    logic [8:0] ain, bin, pick;
    logic [1:0] win;
  } turn_t;

  turn_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] m_ain, m_bin, occ, hm, wc, bc, ac, pk;
    logic [1:0] mw;
    bit         legal, done;
    int         cyc;

    //            rst   hm      wc      bc      ac      err  ain     bin     pick    win
    tbl[0]  = '{1'b1, 9'h001, 9'h000, 9'h000, 9'h000, 1'b0, 9'h001, 9'h010, 9'h010, 2'b00};
    tbl[1]  = '{1'b0, 9'h100, 9'h000, 9'h000, 9'h0AA, 1'b0, 9'h101, 9'h012, 9'h002, 2'b00};
    tbl[2]  = '{1'b0, 9'h010, 9'h000, 9'h000, 9'h000, 1'b1, 9'h101, 9'h012, 9'h000, 2'b00};
    tbl[3]  = '{1'b0, 9'h003, 9'h000, 9'h000, 9'h000, 1'b1, 9'h101, 9'h012, 9'h000, 2'b00};
    tbl[4]  = '{1'b1, 9'h001, 9'h000, 9'h000, 9'h000, 1'b0, 9'h001, 9'h010, 9'h010, 2'b00};
    tbl[5]  = '{1'b0, 9'h002, 9'h000, 9'h040, 9'h000, 1'b0, 9'h003, 9'h050, 9'h040, 2'b00};
    tbl[6]  = '{1'b0, 9'h004, 9'h000, 9'h000, 9'h000, 1'b0, 9'h007, 9'h050, 9'h000, 2'b01};
    tbl[7]  = '{1'b1, 9'h001, 9'h010, 9'h000, 9'h000, 1'b0, 9'h001, 9'h010, 9'h010, 2'b00};
    tbl[8]  = '{1'b0, 9'h004, 9'h002, 9'h000, 9'h000, 1'b0, 9'h005, 9'h012, 9'h002, 2'b00};
    tbl[9]  = '{1'b0, 9'h008, 9'h040, 9'h000, 9'h000, 1'b0, 9'h00D, 9'h052, 9'h040, 2'b00};
    tbl[10] = '{1'b0, 9'h080, 9'h020, 9'h000, 9'h000, 1'b0, 9'h08D, 9'h072, 9'h020, 2'b00};
    tbl[11] = '{1'b0, 9'h100, 9'h000, 9'h000, 9'h000, 1'b0, 9'h18D, 9'h072, 9'h000, 2'b11};

    tick();
    do_reset(1'b0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].restart) do_reset(i[0]);
      do_turn($sformatf("tbl%0d", i), tbl[i].hm, tbl[i].wc, tbl[i].bc, tbl[i].ac,
              tbl[i].err, tbl[i].ain, tbl[i].bin, tbl[i].pick, tbl[i].win);
      if (tbl[i].win != 2'b00) done_hold(tbl[i].ain, tbl[i].bin, tbl[i].win);
    end

    // Random games against the board-level model.
    for (int g = 0; g < 40; g++) begin
      do_reset(g[0]);
      m_ain = '0; m_bin = '0; done = 1'b0;
      for (int t = 0; t < 24 && !done; t++) begin
        int empt[$];
        occ = m_ain | m_bin;
        for (int i = 0; i < 9; i++) if (!occ[i]) empt.push_back(i);
        if ($urandom_range(0, 9) < 2) hm = 9'($urandom);
        else hm = 9'(1) << empt[$urandom_range(0, empt.size() - 1)];
        wc = 9'($urandom) & 9'($urandom) & 9'($urandom);
        bc = 9'($urandom) & 9'($urandom);
        ac = $urandom_range(0, 1) ? (9'($urandom) & 9'h0AA) : 9'h000;
        legal = ($countones(hm) == 1) && ((hm & occ) == '0);
        pk = '0; mw = 2'b00;
        if (legal) begin
          m_ain = m_ain | hm;
          if (m_line(m_ain)) mw = 2'b01;
          else if ((m_ain | m_bin) == 9'h1FF) mw = 2'b11;
          else begin
            pk = m_pick(wc, bc, ac, m_ain | m_bin);
            m_bin = m_bin | pk;
            if (m_line(m_bin)) mw = 2'b10;
            else if ((m_ain | m_bin) == 9'h1FF) mw = 2'b11;
          end
        end
        do_turn($sformatf("rnd%0d.%0d", g, t), hm, wc, bc, ac, !legal, m_ain, m_bin, pk, mw);
        done = (mw != 2'b00);
      end
    end

    // Slow instance: abort mid-think and on the final think cycle.
    abort_think(1'b0, 1);
    abort_think(1'b1, 3);

    rst4 = 1'b1; tick(); rst4 = 1'b0;
    hm4 = 9'h001; hv4 = 1'b1; tick(); hv4 = 1'b0;
    chk("think4.check_h", st4, StCheckH);
    tick();
    cyc = 0;
    while (st4 == StThink && cyc < 20) begin
      if (cm4 != '0) cyc = 100;
      tick();
      cyc++;
    end
    chk("think4.cycles", cyc, THINK4);
    chk("think4.comp_move", cm4, 9'h010);
    chk("think4.bin", bin4, 9'h010);
    chk("think4.state", st4, StCheckC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
